fp32_addsub_stage: RTL and testbench

//  Multi-cycle IEEE-754 single-precision add/subtract engine behind the Nios-style custom-instruction top.

---
 rtl/fp32_addsub_stage_pkg.sv | 31 +++
 rtl/fp32_lzc.sv | 19 +
 rtl/fp32_addsub_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_fp32_addsub_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_addsub_stage_pkg.sv
// Shared definitions for the fp32 add/subtract engine and its helpers:
// IEEE-754 single field widths, special encodings and FSM states.
package fp32_addsub_stage_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = 24;   // significand with hidden bit
    localparam int unsigned EXT_W  = 27;   // significand + guard, round, sticky
    localparam int unsigned SUM_W  = 28;   // extended significand + carry

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      FP_QNAN = 32'h7FC00000;
    localparam logic [31:0]      POS_INF = 32'h7F800000;
    localparam logic [31:0]      NEG_INF = 32'hFF800000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ADD    = 3'd3,
        ST_NORM   = 3'd4,
        ST_ROUND  = 3'd5
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp32_lzc.sv
// 28-bit combinational leading-zero counter; an all-zero input reports 28.
module fp32_lzc
    import fp32_addsub_stage_pkg::*;
(
    input  logic [SUM_W-1:0] value,
    output logic [4:0]       count
);

    // Scan upward so the most significant set bit has the last word.
    always_comb begin
        count = 5'd28;
        for (int unsigned i = 0; i < SUM_W; i++) begin
            if (value[i]) begin
                count = 5'(SUM_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp32_addsub_stage.sv
// Multi-cycle IEEE-754 single-precision add/subtract engine.
// One operation in flight, fixed 5-cycle latency, round-to-nearest-even,
// denormal inputs and results flushed to signed zero.
module fp32_addsub_stage
    import fp32_addsub_stage_pkg::*;
#(
    parameter int unsigned LATENCY = 5,
    parameter logic [31:0] QNAN    = FP_QNAN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic        n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    if (LATENCY != 5) begin : g_latency_check
        $error("fp32_addsub_stage: LATENCY is fixed by the FSM and must be 5");
    end

    localparam logic [EXT_W-1:0] EXT_ONES = '1;

    state_t             state;

    logic [31:0]        op_a, op_b;
    logic               sign_a, sign_b;
    logic [EXP_W-1:0]   exp_a, exp_b;
    logic [SIG_W-1:0]   sig_a, sig_b;
    logic               spec_valid;
    logic [31:0]        spec_val;
    logic               res_sign, eff_sub;
    logic signed [9:0]  exp_r;
    logic [EXT_W-1:0]   big_ext, small_ext, norm_ext;
    logic [SUM_W-1:0]   sum;

    // Unpack stage combinational signals
    fp32_t              fa, fb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic               u_spec;
    logic [31:0]        u_spec_val;
    logic [SIG_W-1:0]   u_sig_a, u_sig_b;

    // Align stage combinational signals
    logic               a_ge;
    logic [EXP_W-1:0]   big_e, small_e, exp_diff;
    logic [SIG_W-1:0]   big_sig, small_sig;
    logic [4:0]         shamt;
    logic [EXT_W-1:0]   small_full, lost, al_big, al_small;
    logic               al_sign;

    // Normalise / round stage combinational signals
    logic [4:0]         lz, nm_shift;
    logic [EXT_W-1:0]   nm_ext;
    logic signed [9:0]  nm_exp, rd_exp;
    logic               nm_cancel, nm_flush;
    logic               rd_up;
    logic [SIG_W:0]     rd_sum;
    logic [FRAC_W-1:0]  rd_frac;
    logic [31:0]        rd_word;

    fp32_lzc u_lzc (
        .value (sum),
        .count (lz)
    );

    // Classify operands; specials are settled here and bypass the datapath.
    always_comb begin
        fa     = fp32_t'(op_a);
        fb     = fp32_t'(op_b);
        a_zero = (fa.exp == '0);
        b_zero = (fb.exp == '0);
        a_inf  = (fa.exp == EXP_MAX) && (fa.frac == '0);
        b_inf  = (fb.exp == EXP_MAX) && (fb.frac == '0);
        a_nan  = (fa.exp == EXP_MAX) && (fa.frac != '0);
        b_nan  = (fb.exp == EXP_MAX) && (fb.frac != '0);
        u_sig_a = a_zero ? '0 : {1'b1, fa.frac};
        u_sig_b = b_zero ? '0 : {1'b1, fb.frac};
        u_spec     = 1'b0;
        u_spec_val = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign))) begin
            u_spec     = 1'b1;
            u_spec_val = QNAN;
        end else if (a_inf) begin
            u_spec     = 1'b1;
            u_spec_val = fa.sign ? NEG_INF : POS_INF;
        end else if (b_inf) begin
            u_spec     = 1'b1;
            u_spec_val = fb.sign ? NEG_INF : POS_INF;
        end else if (a_zero && b_zero) begin
            u_spec     = 1'b1;
            u_spec_val = {fa.sign & fb.sign, 31'b0};
        end
    end

    // Order operands by magnitude and shift the smaller one into G/R/S.
    always_comb begin
        a_ge       = {exp_a, sig_a} >= {exp_b, sig_b};
        big_e      = a_ge ? exp_a : exp_b;
        small_e    = a_ge ? exp_b : exp_a;
        big_sig    = a_ge ? sig_a : sig_b;
        small_sig  = a_ge ? sig_b : sig_a;
        al_sign    = a_ge ? sign_a : sign_b;
        exp_diff   = big_e - small_e;
        // Shifts of 27 or more leave only the sticky bit.
        shamt      = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
        small_full = {small_sig, 3'b000};
        lost       = small_full & ~(EXT_ONES << shamt);
        al_small   = (small_full >> shamt) | {{(EXT_W-1){1'b0}}, |lost};
        al_big     = {big_sig, 3'b000};
    end

    // Normalise the raw sum: carry shifts right, otherwise shift left by lzc-1.
    always_comb begin
        nm_shift = lz - 5'd1;
        if (sum[SUM_W-1]) begin
            nm_ext = {sum[SUM_W-1:2], sum[1] | sum[0]};
            nm_exp = exp_r + 10'sd1;
        end else begin
            nm_ext = sum[EXT_W-1:0] << nm_shift;
            nm_exp = exp_r - $signed({5'b00000, nm_shift});
        end
        nm_cancel = (sum == '0);
        nm_flush  = (nm_exp <= 10'sd0);
    end

    // Round to nearest even and pack, saturating to infinity on overflow.
    always_comb begin
        rd_up  = norm_ext[2] & (norm_ext[1] | norm_ext[0] | norm_ext[3]);
        rd_sum = {1'b0, norm_ext[EXT_W-1:3]} + {{SIG_W{1'b0}}, rd_up};
        if (rd_sum[SIG_W]) begin
            rd_exp  = exp_r + 10'sd1;
            rd_frac = rd_sum[SIG_W-1:1];
        end else begin
            rd_exp  = exp_r;
            rd_frac = rd_sum[FRAC_W-1:0];
        end
        if (rd_exp >= 10'sd255) begin
            rd_word = res_sign ? NEG_INF : POS_INF;
        end else begin
            rd_word = {res_sign, rd_exp[7:0], rd_frac};
        end
    end

    // Control FSM: sequences the stages and drives busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else if (clk_en) begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    busy <= start;
                    if (start) begin
                        state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: state <= ST_ALIGN;
                ST_ALIGN:  state <= ST_ADD;
                ST_ADD:    state <= ST_NORM;
                ST_NORM:   state <= ST_ROUND;
                ST_ROUND: begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Datapath registers, each stage updating its own slice under the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a       <= '0;
            op_b       <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            exp_a      <= '0;
            exp_b      <= '0;
            sig_a      <= '0;
            sig_b      <= '0;
            spec_valid <= 1'b0;
            spec_val   <= '0;
            res_sign   <= 1'b0;
            eff_sub    <= 1'b0;
            exp_r      <= '0;
            big_ext    <= '0;
            small_ext  <= '0;
            sum        <= '0;
            norm_ext   <= '0;
            result     <= '0;
        end else if (clk_en) begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a <= dataa;
                        op_b <= datab ^ {n, 31'b0};
                    end
                end
                ST_UNPACK: begin
                    sign_a     <= fa.sign;
                    sign_b     <= fb.sign;
                    exp_a      <= fa.exp;
                    exp_b      <= fb.exp;
                    sig_a      <= u_sig_a;
                    sig_b      <= u_sig_b;
                    spec_valid <= u_spec;
                    spec_val   <= u_spec_val;
                end
                ST_ALIGN: begin
                    res_sign  <= al_sign;
                    eff_sub   <= sign_a ^ sign_b;
                    exp_r     <= $signed({2'b00, big_e});
                    big_ext   <= al_big;
                    small_ext <= al_small;
                end
                ST_ADD: begin
                    sum <= eff_sub ? ({1'b0, big_ext} - {1'b0, small_ext})
                                   : ({1'b0, big_ext} + {1'b0, small_ext});
                end
                ST_NORM: begin
                    norm_ext <= nm_ext;
                    exp_r    <= nm_exp;
                    // Exact cancellation gives +0; underflow keeps the sign.
                    if (!spec_valid && (nm_cancel || nm_flush)) begin
                        spec_valid <= 1'b1;
                        spec_val   <= nm_cancel ? 32'h0 : {res_sign, 31'b0};
                    end
                end
                ST_ROUND: begin
                    result <= spec_valid ? spec_val : rd_word;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_addsub_stage.sv
// Self-checking bench for fp32_addsub_stage: directed vectors, handshake
// sequences and random operands against a real-arithmetic reference.
module tb_fp32_addsub_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic        n = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int errors = 0;
    int checks = 0;

    fp32_addsub_stage #(.LATENCY(5), .QNAN(32'h7FC00000)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Float bits to real, with denormal inputs taken as signed zero.
    function automatic real to_real(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'h00) return $bitstoreal({x[31], 63'b0});
        e = (x[30:23] == 8'hFF) ? 11'h7FF : 11'({3'b000, x[30:23]} + 11'd896);
        return $bitstoreal({x[31], e, x[22:0], 29'b0});
    endfunction

    // Real to float bits: round to nearest even, overflow to inf, tiny to signed zero.
    function automatic logic [31:0] from_real(input real r);
        logic [63:0] d;
        logic [52:0] m;
        logic [23:0] top;
        logic [28:0] rest;
        logic [24:0] t25;
        logic        up;
        int          fe;
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF) return (d[51:0] != '0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'b0};
        if (d[62:52] == 11'h000) return {d[63], 31'b0};
        fe   = int'(d[62:52]) - 1023 + 127;
        m    = {1'b1, d[51:0]};
        top  = m[52:29];
        rest = m[28:0];
        up   = (rest > 29'h10000000) || ((rest == 29'h10000000) && top[0]);
        t25  = {1'b0, top} + 25'(up);
        if (t25[24]) begin
            fe++;
            t25 = t25 >> 1;
        end
        if (fe >= 255) return {d[63], 8'hFF, 23'b0};
        if (fe <= 0) return {d[63], 31'b0};
        return {d[63], 8'(fe), t25[22:0]};
    endfunction

    function automatic logic [31:0] ref_addsub(input logic [31:0] a, input logic [31:0] b_in, input logic sub);
        logic [31:0] b;
        b = b_in ^ {sub, 31'b0};
        if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
            return 32'h7FC00000;
        return from_real(to_real(a) + to_real(b));
    endfunction

    // Issue one operation and wait (bounded) for done; lat=0 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        dataa = a;
        datab = b;
        n     = sub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        res = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                res = result;
                break;
            end
        end
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] res, a, b, exp_v;
        int          lat, ndone, first_at, prev_at;
        int unsigned mode;
        logic [7:0]  e;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check32("reset_result", result, 32'h0);
        check_int("reset_done", int'(done), 0);
        check_int("reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors
        vecs.push_back('{32'h437F0000, 32'h43000000, 1'b0, 32'h43BF8000});
        vecs.push_back('{32'h437F0000, 32'h43000000, 1'b1, 32'h42FE0000});
        vecs.push_back('{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000});
        vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000});
        vecs.push_back('{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001});
        vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000});
        vecs.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000});
        vecs.push_back('{32'h00000001, 32'h00000000, 1'b0, 32'h00000000});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000});
        vecs.push_back('{32'h00000000, 32'h80000000, 1'b0, 32'h00000000});
        vecs.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000});
        vecs.push_back('{32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000});
        vecs.push_back('{32'h00800000, 32'h80800001, 1'b0, 32'h80000000});
        vecs.push_back('{32'h40400000, 32'h80000000, 1'b0, 32'h40400000});
        vecs.push_back('{32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000});
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, res, lat);
            check32($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check_int($sformatf("vec%0d_latency", i), lat, 5);
        end

        // start pulses while busy are ignored
        @(negedge clk);
        dataa = 32'h437F0000; datab = 32'h43000000; n = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        dataa = 32'h3F800000;
        ndone = 0; first_at = 0; res = '0;
        for (int i = 1; i <= 14; i++) begin
            start = (i <= 3);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first_at == 0) begin
                    first_at = i;
                    res = result;
                end
            end
        end
        start = 1'b0;
        check_int("busy_start_done_count", ndone, 1);
        check_int("busy_start_done_at", first_at, 5);
        check32("busy_start_result", res, 32'h43BF8000);

        // clk_en low freezes the operation
        @(negedge clk);
        dataa = 32'h40400000; datab = 32'h3F800000; n = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        first_at = 0; res = '0;
        for (int i = 1; i <= 20; i++) begin
            clk_en = !(i >= 2 && i <= 4);
            @(posedge clk);
            #1;
            if (done && first_at == 0) begin
                first_at = i;
                res = result;
            end
        end
        clk_en = 1'b1;
        check_int("clken_done_at", first_at, 8);
        check32("clken_result", res, 32'h40000000);

        // start held high: one op per 6 cycles, done never back-to-back
        @(negedge clk);
        dataa = 32'h437F0000; datab = 32'h43000000; n = 1'b0; start = 1'b1;
        ndone = 0; first_at = 0; prev_at = 0; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (prev_at != 0 && (i - prev_at) != 6) lat++;
                if (first_at == 0) first_at = i;
                check32($sformatf("b2b_result_%0d", ndone), result, 32'h43BF8000);
                prev_at = i;
            end
        end
        start = 1'b0;
        check_int("b2b_done_count", ndone, 3);
        check_int("b2b_first_done", first_at, 6);
        check_int("b2b_bad_gaps", lat, 0);
        repeat (8) @(posedge clk);
        #1;

        // reset in ALIGN abandons the op
        @(negedge clk);
        dataa = 32'h3F800000; datab = 32'h3F800000; n = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check32("rst_mid_result", result, 32'h0);
        check_int("rst_mid_busy", int'(busy), 0);
        check_int("rst_mid_done", int'(done), 0);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check_int("rst_mid_no_done", ndone, 0);
        run_op(32'h437F0000, 32'h43000000, 1'b1, res, lat);
        check32("rst_fresh_result", res, 32'h42FE0000);
        check_int("rst_fresh_latency", lat, 5);

        // Random operands, biased toward close and widely separated exponents
        for (int k = 0; k < 4000; k++) begin
            a = $urandom;
            b = $urandom;
            e = a[30:23];
            mode = $urandom_range(0, 7);
            case (mode)
                0, 1, 2: b[30:23] = e + 8'($urandom_range(0, 6)) - 8'd3;
                3:       b[30:23] = e - 8'(26 + $urandom_range(0, 8));
                4:       b[30:0]  = a[30:0];
                5:       b[30:23] = e;
                6:       b[30:23] = e - 8'($urandom_range(20, 30));
                default: ;
            endcase
            mode = $urandom_range(0, 1);
            exp_v = ref_addsub(a, b, mode[0]);
            run_op(a, b, mode[0], res, lat);
            check32($sformatf("rand%0d_%h_%h_n%0d", k, a, b, mode[0]), res, exp_v);
            check_int($sformatf("rand%0d_latency", k), lat, 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
